pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It combines I-cache and D-cache completion, load-use hazards, MEM-stage branch/jump resolution and WB-stage halt. From these it drives each latch's enable/flush pair and masks the memory request strobes. It remembers a hit that arrives before its partner, so no access is re-issued and no hit is lost. It also keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  I-cache hit, single-cycle pulse
dhit  in  1  D-cache hit, single-cycle pulse
dREN_MEM  in  1  load in MEM stage (raw, from EX/MEM latch)
dWEN_MEM  in  1  store in MEM stage (raw)
ldhaz  in  1  load-use hazard detected in ID (ID/EX load rt matches IF/ID rs or rt)
br_taken_MEM  in  1  branch taken or jump resolved in MEM
halt_WB  in  1  halt instruction in WB
dREN_out  out  1  masked load request to D-cache
dWEN_out  out  1  masked store request to D-cache
iREN_out  out  1  masked fetch request to I-cache
pc_en  out  1  PC load enable
ifid_en, ifid_flush  out  1 each  IF/ID latch control
idex_en, idex_flush  out  1 each  ID/EX latch control
exmem_en, exmem_flush  out  1 each  EX/MEM latch control
memwb_en, memwb_flush  out  1 each  MEM/WB latch control
halt  out  1  sticky processor-halted flag
stall_cnt  out  CNT_W  saturating count of stalled cycles
flush_cnt  out  CNT_W  saturating count of branch-flush events

Behaviour:
- State: halted flag, i_done flag, d_done flag, two counters. All registers reset to 0 asynchronously on nRST low.
- While nRST is low, all enable/flush/request outputs are 0 (gated combinationally), halt=0, and both counters are 0.
- dacc = dREN_MEM | dWEN_MEM.
- iok = ihit | i_done.
- dok = !dacc | dhit | d_done.
- adv = iok & dok & !halted.
- Request masking:
  - dREN_out = dREN_MEM & !d_done & !halted.
  - dWEN_out = dWEN_MEM & !d_done & !halted.
  - iREN_out = !i_done & !halted.
- Flag update when adv=0 and not halted:
  - i_done is set by ihit.
  - d_done is set by dhit & dacc.
- Flag update when adv=1: both flags clear on the next edge. This covers ihit and dhit in the same cycle, or one hit arriving while the other flag is already set.
- A flag set never re-raises its request. Example: dhit arrives first, then the pipeline waits for ihit with dREN_out=0.
- adv=0 (memory stall): all *_en=0, all *_flush=0, pc_en=0.
- adv=1, normal: all *_en=1, pc_en=1, all *_flush=0.
- adv=1 & br_taken_MEM: all *_en=1, pc_en=1 (PC takes target); ifid_flush=idex_flush=exmem_flush=1; memwb_flush=0. The instruction in MEM retires.
- adv=1 & ldhaz & !br_taken_MEM: pc_en=0 and ifid_en=0 (hold); idex_en=1 with idex_flush=1 (bubble); exmem and memwb advance normally.
- Priority: halted > memory stall > branch flush > load-use. br_taken_MEM suppresses ldhaz in the same cycle.
- A flush is only ever asserted together with its enable.
- Halt:
  - halt_WB=1 sets the halted flag on the next edge regardless of adv; it is sticky until nRST.
  - In the halt_WB cycle itself, outputs follow the normal rules.
  - Once halted=1: halt=1, all enables/flushes/requests 0, flags held at 0, counters frozen.
- stall_cnt increments by 1 on each edge where !halted & (!adv | (ldhaz & !br_taken_MEM)).
- flush_cnt increments on each edge where adv & br_taken_MEM.
- Both counters saturate at 2^CNT_W-1; no wrap-around.
- nRST asserted mid-wait clears the flags immediately. After release, requests re-issue from scratch.

Test Plan:
- Reset: hold nRST=0 with ihit=1 and dREN_MEM=1 -> all outputs 0. Release nRST, pulse ihit with dacc=0 -> all *_en=1, pc_en=1, stall_cnt=0.
- Split hits: dREN_MEM=1, dhit at cycle 2, ihit at cycle 5 -> dREN_out drops at cycle 3; enables stay 0 through cycle 4; adv=1 at cycle 5; stall_cnt=4 (cycles 1–4); both flags 0 at cycle 6.
- Same-cycle hits: dWEN_MEM=1, ihit=dhit=1 in one cycle -> adv that cycle with no stall; flags remain 0.
- Branch and hazard together: ihit=1, dacc=0, br_taken_MEM=1, ldhaz=1 -> ifid/idex/exmem flush=1, memwb_flush=0, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- Load-use alone: ihit=1, ldhaz=1 -> pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1, stall_cnt +1.
- Halt and saturation:
  - CNT_W=2, 5 consecutive stall cycles -> stall_cnt=3.
  - Then halt_WB pulse -> halt=1 next cycle, all enables 0.
  - Further ihit pulses -> no change.
  - nRST pulse -> halt=0, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline latch/PC sequencer combining cache completion, load-use,
// MEM-stage branch flush and WB halt, with saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_MEM,
  input  logic             dWEN_MEM,
  input  logic             ldhaz,
  input  logic             br_taken_MEM,
  input  logic             halt_WB,
  output logic             dREN_out,
  output logic             dWEN_out,
  output logic             iREN_out,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic halted, i_done, d_done;
  logic dacc, adv, go, br, lu, s_inc, f_inc;
  always_comb begin
    dacc  = dREN_MEM | dWEN_MEM;
    adv   = (ihit | i_done) & (!dacc | dhit | d_done) & !halted;
    go    = nRST & adv;
    br    = go & br_taken_MEM;
    lu    = go & ldhaz & !br_taken_MEM;
    s_inc = !halted & (!adv | (ldhaz & !br_taken_MEM)) & ~&stall_cnt;
    f_inc = adv & br_taken_MEM & ~&flush_cnt;
  end
  // nRST gating keeps every strobe low while reset is held
  assign dREN_out    = nRST & dREN_MEM & !d_done & !halted;
  assign dWEN_out    = nRST & dWEN_MEM & !d_done & !halted;
  assign iREN_out    = nRST & !i_done & !halted;
  assign pc_en       = go & !lu;
  assign ifid_en     = go & !lu;
  assign ifid_flush  = br;
  assign idex_en     = go;
  assign idex_flush  = br | lu;
  assign exmem_en    = go;
  assign exmem_flush = br;
  assign memwb_en    = go;
  assign memwb_flush = 1'b0;
  assign halt        = halted;
  // a hit that arrives before its partner is remembered until the pipeline advances
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      halted    <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      halted    <= halted | halt_WB;
      i_done    <= !halted & !adv & (i_done | ihit);
      d_done    <= !halted & !adv & (d_done | (dhit & dacc));
      stall_cnt <= stall_cnt + CNT_W'(s_inc);
      flush_cnt <= flush_cnt + CNT_W'(f_inc);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven scoreboard check of pipe_hazard_ctrl,
// with a CNT_W=2 twin sharing the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0, dhit = 1'b0, dREN_MEM = 1'b0, dWEN_MEM = 1'b0;
  logic ldhaz = 1'b0, br_taken_MEM = 1'b0, halt_WB = 1'b0;
  logic dREN_out, dWEN_out, iREN_out, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_dren, s_dwen, s_iren, s_pc, s_ifen, s_iffl, s_ixen, s_ixfl, s_xmen, s_xmfl;
  logic s_mwen, s_mwfl, s_halt;
  logic [1:0] s_stall, s_flush;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_MEM(dREN_MEM),
    .dWEN_MEM(dWEN_MEM), .ldhaz(ldhaz), .br_taken_MEM(br_taken_MEM), .halt_WB(halt_WB),
    .dREN_out(dREN_out), .dWEN_out(dWEN_out), .iREN_out(iREN_out), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_MEM(dREN_MEM),
    .dWEN_MEM(dWEN_MEM), .ldhaz(ldhaz), .br_taken_MEM(br_taken_MEM), .halt_WB(halt_WB),
    .dREN_out(s_dren), .dWEN_out(s_dwen), .iREN_out(s_iren), .pc_en(s_pc),
    .ifid_en(s_ifen), .ifid_flush(s_iffl), .idex_en(s_ixen), .idex_flush(s_ixfl),
    .exmem_en(s_xmen), .exmem_flush(s_xmfl), .memwb_en(s_mwen),
    .memwb_flush(s_mwfl), .halt(s_halt), .stall_cnt(s_stall), .flush_cnt(s_flush)
  );

  // in  = {nRST, ihit, dhit, dREN_MEM, dWEN_MEM, ldhaz, br_taken_MEM, halt_WB}
  // req = {dREN_out, dWEN_out, iREN_out}
  // ctl = {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
  typedef struct {
    string      nm;
    logic [7:0] in;
    logic [2:0] req;
    logic       hlt;
    logic [8:0] ctl;
    int         sc;
    int         fc;
  } vec_t;

  localparam logic [8:0] STL = 9'b000000000;
  localparam logic [8:0] RUN = 9'b110101010;
  localparam logic [8:0] BRF = 9'b111111110;
  localparam logic [8:0] LDU = 9'b000111010;

  vec_t tbl[$];
  vec_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t v(string nm, logic [7:0] in, logic [2:0] req, logic hlt,
                             logic [8:0] ctl, int sc, int fc);
    vec_t r;
    r.nm = nm; r.in = in; r.req = req; r.hlt = hlt; r.ctl = ctl; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(string nm, string what, int got, int want);
    if (got != want) begin
      n_bad++;
      $display("FAIL %s %s: got %0d want %0d", nm, what, got, want);
    end
  endtask

  initial begin
    vec_t e;
    logic [12:0] got, want;
    tbl.push_back(v("rst0",      8'b01010000, 3'b000, 0, STL, 0, 0));
    tbl.push_back(v("rst1",      8'b01010000, 3'b000, 0, STL, 0, 0));
    tbl.push_back(v("first",     8'b11000000, 3'b001, 0, RUN, 0, 0));
    tbl.push_back(v("sp1",       8'b10010000, 3'b101, 0, STL, 0, 0));
    tbl.push_back(v("sp2_dhit",  8'b10110000, 3'b101, 0, STL, 1, 0));
    tbl.push_back(v("sp3",       8'b10010000, 3'b001, 0, STL, 2, 0));
    tbl.push_back(v("sp4",       8'b10010000, 3'b001, 0, STL, 3, 0));
    tbl.push_back(v("sp5_ihit",  8'b11010000, 3'b001, 0, RUN, 4, 0));
    tbl.push_back(v("sp6",       8'b10010000, 3'b101, 0, STL, 4, 0));
    tbl.push_back(v("same",      8'b11101000, 3'b011, 0, RUN, 5, 0));
    tbl.push_back(v("same_aft",  8'b11000000, 3'b001, 0, RUN, 5, 0));
    tbl.push_back(v("br_lh",     8'b11000110, 3'b001, 0, BRF, 5, 0));
    tbl.push_back(v("ldu",       8'b11000100, 3'b001, 0, LDU, 5, 1));
    tbl.push_back(v("run",       8'b11000000, 3'b001, 0, RUN, 6, 1));
    tbl.push_back(v("br_stall",  8'b10000010, 3'b001, 0, STL, 6, 1));
    tbl.push_back(v("i_early",   8'b11010000, 3'b101, 0, STL, 7, 1));
    tbl.push_back(v("i_wait",    8'b10010000, 3'b100, 0, STL, 8, 1));
    tbl.push_back(v("d_late",    8'b10110000, 3'b100, 0, RUN, 9, 1));
    tbl.push_back(v("mw1",       8'b10110000, 3'b101, 0, STL, 9, 1));
    tbl.push_back(v("mw_rst",    8'b00010000, 3'b000, 0, STL, 0, 0));
    tbl.push_back(v("mw_rel",    8'b10010000, 3'b101, 0, STL, 0, 0));
    tbl.push_back(v("mw_ok",     8'b11110000, 3'b101, 0, RUN, 1, 0));
    tbl.push_back(v("hwb",       8'b11000001, 3'b001, 0, RUN, 1, 0));
    tbl.push_back(v("halted",    8'b11010100, 3'b000, 1, STL, 1, 0));
    tbl.push_back(v("halted2",   8'b11100010, 3'b000, 1, STL, 1, 0));
    tbl.push_back(v("halted3",   8'b11000000, 3'b000, 1, STL, 1, 0));
    tbl.push_back(v("rel_rst",   8'b00000000, 3'b000, 0, STL, 0, 0));
    tbl.push_back(v("after",     8'b11000000, 3'b001, 0, RUN, 0, 0));
    foreach (tbl[i]) begin
      @(posedge CLK);
      #1;
      {nRST, ihit, dhit, dREN_MEM, dWEN_MEM, ldhaz, br_taken_MEM, halt_WB} = tbl[i].in;
      sb.push_back(tbl[i]);
      @(negedge CLK);
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: got empty queue want an entry");
      end else begin
        e = sb.pop_front();
        n_vec++;
        got  = {dREN_out, dWEN_out, iREN_out, halt, pc_en, ifid_en, ifid_flush, idex_en,
                idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush};
        want = {e.req, e.hlt, e.ctl};
        if (got !== want) begin
          n_bad++;
          $display("FAIL %s ctl: got %b want %b", e.nm, got, want);
        end
        chk(e.nm, "stall_cnt", int'(stall_cnt), e.sc);
        chk(e.nm, "flush_cnt", int'(flush_cnt), e.fc);
        chk(e.nm, "sat_stall", int'(s_stall), (e.sc > 3) ? 3 : e.sc);
        chk(e.nm, "sat_flush", int'(s_flush), (e.fc > 3) ? 3 : e.fc);
      end
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
